mmd_divider_ctrl: RTL and testbench
===================================

# mmd_divider_ctrl

Multi-modulus divider controller; the consuming end of the delta-sigma modulator's 5-bit output word in the fractional-N PLL feedback path. Each output period is exactly N = N_INT + Div_In clocks, with N clamped to a legal range. At the end of every period it strobes Div_Req so the modulator advances and presents the next offset. The averaged divide ratio therefore tracks the modulator's fractional input.

## Interface
- N_INT, 32: integer divide base.
- CNT_W, 7: counter width; maximum ratio is 2^CNT_W.
- N_MIN, 4: minimum legal ratio.

- Clk  in  1  divider input clock (VCO-derived); single clock domain.
- reset  in  1  asynchronous, active-high reset.
- En  in  1  run enable.
- Div_In  in  5  signed two's-complement ratio offset from the DSM (range -16..+15).
- Div_Req  out  1  one-cycle strobe; Div_In is sampled on the rising edge where Div_Req=1.
- Div_Out  out  1  divided clock.
- Cur_Ratio  out  CNT_W+1  ratio of the period in progress.

## Operation
- State register: IDLE, LOAD, COUNT; down-counter cnt[CNT_W-1:0].
- **Reset:**
  - state=IDLE, cnt=0, Cur_Ratio=0.
  - Div_Req=0, Div_Out=0.
  - Asynchronous assertion mid-period aborts the period immediately; no Div_Req is issued.
- **IDLE:** all outputs 0. On En=1, go to LOAD.
- **LOAD:** one cycle with Div_Req=1. On the edge:
  - capture N from Div_In;
  - cnt ← N-1, Cur_Ratio ← N;
  - go to COUNT.
- **COUNT:** cnt decrements every clock.
  - At cnt==0 with En=1: Div_Req=1. On the edge, capture a new N, reload cnt ← N-1, update Cur_Ratio, and stay in COUNT.
  - At cnt==0 with En=0: Div_Req stays 0. Go to IDLE on the edge; Cur_Ratio holds its last value.
  - En changes mid-period do not shorten or extend the current period.
- **Ratio arithmetic:**
  - N_raw = N_INT + sign-extended Div_In, computed at CNT_W+2 bits, signed.
  - If N_raw < N_MIN, N = N_MIN.
  - If N_raw > 2^CNT_W, N = 2^CNT_W.
  - Otherwise N = N_raw.
  - Clamping is silent; there is no flag.
- **Div_Out:** registered, aligned with cnt. Behaviour per Configuration.

## Timing
- Period is exactly Cur_Ratio clocks (cnt runs N-1 to 0). Period boundaries carry no dead cycle.
- Startup: 1 LOAD cycle, then the first period begins on the next cycle.
- Div_Req is high on the last cycle of each period (cnt==0) and on the LOAD cycle. It is never high on two consecutive cycles unless N=1, which clamping makes impossible.
- Div_In must be stable in the cycle Div_Req=1. The DSM advances on that same edge.
- Cur_Ratio updates on the edge that reloads cnt.
- Div_Out changes only on Clk edges, driven from a flop, so it is glitch-free.

## Configuration
- Macro: MMD_DUTY50_EN.
- **Defined:** Div_Out=1 while cnt ≥ ceil(Cur_Ratio/2), i.e. the first floor(N/2) cycles of the period. With odd N the extra cycle is low.
- **Undefined:** Div_Out is a one-cycle pulse on the last cycle of the period (cnt==0), coincident with the period-end Div_Req. It is 0 in LOAD.

## Test plan
- **Basic ratio:** reset 20 ns, then En=1, Div_In=0, N_INT=32.
  - Div_Req on the LOAD cycle, then every 32 clocks.
  - Cur_Ratio=32.
  - With MMD_DUTY50_EN: Div_Out 16 high / 16 low.
- **Signed offsets:** Div_In sequence -3 (5'b11101), +4, 0 supplied at successive Div_Req strobes.
  - Periods 29, 36, 32 clocks.
  - With duty: Div_Out high 14, 18, 16 clocks.
- **Clamping:** N_INT=8, Div_In=-16 → period 4, Cur_Ratio=4. CNT_W=5, N_INT=30, Div_In=+15 → period 32.
- **Enable drop:** En=0 asserted 5 clocks into a 32-clock period.
  - The period completes at full length; no Div_Req is issued at its end.
  - IDLE follows; Div_Out=0; Cur_Ratio holds 32.
  - Re-assert En → LOAD, then the normal sequence.
- **Async reset mid-count:** reset pulse at cnt=10, asserted between clock edges.
  - All outputs go to 0 immediately, without waiting for an edge.
  - After release with En=1: LOAD at the first edge, then a full period.
- **Pulse mode (macro undefined), Div_In=0:** Div_Out is high exactly one cycle per 32, coincident with the period-end Div_Req.

Source files
------------

// File: rtl/mmd_divider_ctrl_if.sv
// rtl/mmd_divider_ctrl_if.sv - modulator-facing bundle of the multi-modulus divider controller
//
// Purpose: carries the run enable and the delta-sigma ratio offset into the
// divider controller, and the request strobe, divided clock and current ratio
// back out. Clock and reset are not part of the bundle.
//
// Signals:
//   En        master->slave  run enable
//   Div_In    master->slave  signed 5-bit ratio offset (-16..+15)
//   Div_Req   slave->master  one-cycle strobe, Div_In is sampled on its edge
//   Div_Out   slave->master  divided clock (flop-driven)
//   Cur_Ratio slave->master  ratio of the period in progress
//
// Modports: slave = divider controller, master = modulator / stimulus side.
interface mmd_divider_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             En;
  logic [4:0]       Div_In;
  logic             Div_Req;
  logic             Div_Out;
  logic [CNT_W:0]   Cur_Ratio;

  modport slave (
    input  En,
    input  Div_In,
    output Div_Req,
    output Div_Out,
    output Cur_Ratio
  );

  modport master (
    output En,
    output Div_In,
    input  Div_Req,
    input  Div_Out,
    input  Cur_Ratio
  );
endinterface

// File: rtl/mmd_divider_ctrl.sv
// rtl/mmd_divider_ctrl.sv - multi-modulus divider controller for a fractional-N feedback path
//
// Purpose: divides Clk by N = N_INT + Div_In (clamped to N_MIN..2^CNT_W) per
// output period, requesting the next modulator offset at every period end.
//
// Parameters:
//   N_INT  integer divide base
//   CNT_W  down-counter width; largest ratio is 2^CNT_W
//   N_MIN  smallest legal ratio
//
// Ports:
//   Clk    divider input clock
//   reset  asynchronous active-high reset
//   bus    mmd_divider_ctrl_if.slave (En, Div_In in; Div_Req, Div_Out, Cur_Ratio out)
//
// Build option: MMD_DUTY50_EN selects a near-50% duty Div_Out (high for the
// first floor(N/2) cycles of each period). Without it Div_Out is a one-cycle
// pulse on the last cycle of each period.
module mmd_divider_ctrl #(
  parameter int N_INT = 32,
  parameter int CNT_W = 7,
  parameter int N_MIN = 4
) (
  input  logic               Clk,
  input  logic               reset,
  mmd_divider_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic signed [CNT_W+1:0] LP_N_INT = (CNT_W+2)'(N_INT);
  localparam logic signed [CNT_W+1:0] LP_N_MIN = (CNT_W+2)'(N_MIN);
  localparam logic signed [CNT_W+1:0] LP_N_MAX = (CNT_W+2)'(2 ** CNT_W);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W:0]      r_ratio;
  logic                r_div_out;

  logic signed [CNT_W+1:0] w_n_raw;
  logic [CNT_W:0]          w_n;
  logic [CNT_W-1:0]        w_load_cnt;
  logic [CNT_W-1:0]        w_dec_cnt;
  logic                    w_cnt_zero;
  logic                    w_out_load;
  logic                    w_out_dec;
`ifdef MMD_DUTY50_EN
  logic [CNT_W:0]          w_half_new;
  logic [CNT_W:0]          w_half_cur;
`endif

  // Ratio for the period that starts on the next edge, clamped silently.
  always_comb begin
    w_n_raw = LP_N_INT + {{(CNT_W-3){bus.Div_In[4]}}, bus.Div_In};
    w_n     = w_n_raw[CNT_W:0];
    if (w_n_raw < LP_N_MIN) begin
      w_n = (CNT_W+1)'(N_MIN);
    end else if (w_n_raw > LP_N_MAX) begin
      w_n = {1'b1, {CNT_W{1'b0}}};
    end
    w_load_cnt = CNT_W'(w_n - 1'b1);
    w_dec_cnt  = r_cnt - 1'b1;
    w_cnt_zero = (r_cnt == '0);
`ifdef MMD_DUTY50_EN
    // High while cnt >= ceil(N/2): the first floor(N/2) cycles of the period.
    w_half_new = (w_n >> 1) + {{CNT_W{1'b0}}, w_n[0]};
    w_half_cur = (r_ratio >> 1) + {{CNT_W{1'b0}}, r_ratio[0]};
    w_out_load = ({1'b0, w_load_cnt} >= w_half_new);
    w_out_dec  = ({1'b0, w_dec_cnt} >= w_half_cur);
`else
    // N >= N_MIN > 1, so a freshly loaded count is never the last cycle.
    w_out_load = 1'b0;
    w_out_dec  = (r_cnt == CNT_W'(1));
`endif
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ratio   <= '0;
      r_div_out <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_div_out <= 1'b0;
          if (bus.En) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt     <= w_load_cnt;
          r_ratio   <= w_n;
          r_div_out <= w_out_load;
          r_state   <= COUNT;
        end
        COUNT: begin
          if (w_cnt_zero) begin
            // En is only consulted at the period end, so a mid-period change
            // never alters the length of the period in progress.
            if (bus.En) begin
              r_cnt     <= w_load_cnt;
              r_ratio   <= w_n;
              r_div_out <= w_out_load;
            end else begin
              r_div_out <= 1'b0;
              r_state   <= IDLE;
            end
          end else begin
            r_cnt     <= w_dec_cnt;
            r_div_out <= w_out_dec;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_div_out <= 1'b0;
        end
      endcase
    end
  end

  // Request is decoded from flops plus En so that dropping En in the last
  // cycle of a period suppresses that period's request.
  assign bus.Div_Req   = (r_state == LOAD) || ((r_state == COUNT) && w_cnt_zero && bus.En);
  assign bus.Div_Out   = r_div_out;
  assign bus.Cur_Ratio = r_ratio;

endmodule

// File: tb/tb_mmd_divider_ctrl.sv
// tb/tb_mmd_divider_ctrl.sv - self-checking bench for mmd_divider_ctrl
module tb_mmd_divider_ctrl;

  localparam int N_INT = 32;
  localparam int CNT_W = 7;
  localparam int N_MIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmd_divider_ctrl_if #(.CNT_W(7)) bus ();
  mmd_divider_ctrl_if #(.CNT_W(7)) bus_lo ();
  mmd_divider_ctrl_if #(.CNT_W(5)) bus_hi ();

  mmd_divider_ctrl #(.N_INT(N_INT), .CNT_W(CNT_W), .N_MIN(N_MIN)) dut (
    .Clk(clk), .reset(rst), .bus(bus.slave));
  mmd_divider_ctrl #(.N_INT(8), .CNT_W(7), .N_MIN(4)) dut_lo (
    .Clk(clk), .reset(rst), .bus(bus_lo.slave));
  mmd_divider_ctrl #(.N_INT(30), .CNT_W(5), .N_MIN(4)) dut_hi (
    .Clk(clk), .reset(rst), .bus(bus_hi.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;
  int lo_last  = -1;
  int lo_int   = 0;
  int hi_last  = -1;
  int hi_int   = 0;

  // Reference model: phase 0 idle, 1 load cycle, 2 inside a period at
  // position m_pos (0-based) of a period m_n clocks long.
  int m_phase, m_pos, m_n, m_ratio;

  typedef struct {
    int din;
    int period;
    int duty_hi;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ratio_of(input int d, input int base, input int cw);
    int n;
    n = base + d;
    if (n < N_MIN) n = N_MIN;
    if (n > (1 << cw)) n = 1 << cw;
    return n;
  endfunction

  task automatic m_reset();
    m_phase = 0;
    m_pos   = 0;
    m_n     = 0;
    m_ratio = 0;
  endtask

  function automatic int exp_req(input logic e);
    return ((m_phase == 1) || (m_phase == 2 && m_pos == m_n - 1 && e)) ? 1 : 0;
  endfunction

  function automatic int exp_out();
`ifdef MMD_DUTY50_EN
    return (m_phase == 2 && m_pos < m_n / 2) ? 1 : 0;
`else
    return (m_phase == 2 && m_pos == m_n - 1) ? 1 : 0;
`endif
  endfunction

  function automatic int exp_highs(input int period, input int duty_hi);
`ifdef MMD_DUTY50_EN
    return (period > 0) ? duty_hi : 0;
`else
    return (period > 0) ? 1 : 0;
`endif
  endfunction

  task automatic m_advance(input logic e, input int d);
    case (m_phase)
      0: if (e) m_phase = 1;
      1: begin
        m_n = ratio_of(d, N_INT, CNT_W); m_ratio = m_n; m_pos = 0; m_phase = 2;
      end
      default: begin
        if (m_pos == m_n - 1) begin
          if (e) begin
            m_n = ratio_of(d, N_INT, CNT_W); m_ratio = m_n; m_pos = 0;
          end else begin
            m_phase = 0;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
    endcase
  endtask

  // One clock: drive inputs after the falling edge, compare, then let the
  // model take the coming rising edge.
  task automatic cycle(input logic e, input int d);
    @(negedge clk);
    bus.En = e;
    bus.Div_In = 5'(d);
    #1;
    cyc_no++;
    chk("req", int'(bus.Div_Req), exp_req(e));
    chk("out", int'(bus.Div_Out), exp_out());
    chk("ratio", int'(bus.Cur_Ratio), m_ratio);
    if (bus_lo.Div_Req) begin
      if (lo_last >= 0) lo_int = cyc_no - lo_last;
      lo_last = cyc_no;
    end
    if (bus_hi.Div_Req) begin
      if (hi_last >= 0) hi_int = cyc_no - hi_last;
      hi_last = cyc_no;
    end
    m_advance(e, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, highs, reqs, nd;
    bit found;
    logic e;

    tv[0] = '{din: 0,   period: 32, duty_hi: 16};
    tv[1] = '{din: -3,  period: 29, duty_hi: 14};
    tv[2] = '{din: 4,   period: 36, duty_hi: 18};
    tv[3] = '{din: 0,   period: 32, duty_hi: 16};
    tv[4] = '{din: -16, period: 16, duty_hi: 8};
    tv[5] = '{din: 15,  period: 47, duty_hi: 23};

    bus.En = 1'b0;    bus.Div_In = 5'd0;
    bus_lo.En = 1'b0; bus_lo.Div_In = 5'b10000;
    bus_hi.En = 1'b0; bus_hi.Div_In = 5'b01111;
    m_reset();

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_req", int'(bus.Div_Req), 0);
    chk("rst_out", int'(bus.Div_Out), 0);
    chk("rst_ratio", int'(bus.Cur_Ratio), 0);
    @(negedge clk);
    rst = 1'b0;
    bus_lo.En = 1'b1;
    bus_hi.En = 1'b1;

    // Startup: IDLE sees En, then the LOAD cycle.
    cycle(1'b1, tv[0].din);
    chk("start_idle_req", int'(bus.Div_Req), 0);
    cycle(1'b1, tv[0].din);
    chk("start_load_req", int'(bus.Div_Req), 1);

    // Table: each request samples the next entry's offset.
    for (int i = 0; i < 6; i++) begin
      nd = (i < 5) ? tv[i+1].din : 0;
      per = 0;
      highs = 0;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
        cycle(1'b1, nd);
        per++;
        highs += int'(bus.Div_Out);
        if (bus.Div_Req) begin
          found = 1'b1;
          break;
        end
      end
      chk($sformatf("vec%0d_found", i), int'(found), 1);
      chk($sformatf("vec%0d_period", i), per, tv[i].period);
      chk($sformatf("vec%0d_highs", i), highs, exp_highs(tv[i].period, tv[i].duty_hi));
      chk($sformatf("vec%0d_ratio", i), int'(bus.Cur_Ratio), tv[i].period);
    end

    // Clamped instances, running since reset release.
    chk("clamp_lo_period", lo_int, 4);
    chk("clamp_lo_ratio", int'(bus_lo.Cur_Ratio), 4);
    chk("clamp_hi_period", hi_int, 32);
    chk("clamp_hi_ratio", int'(bus_hi.Cur_Ratio), 32);

    // Enable drop 5 clocks into a 32-clock period.
    reqs = 0;
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      cycle(k < 5, 0);
      reqs += int'(bus.Div_Req);
      highs += int'(bus.Div_Out);
    end
    chk("drop_reqs", reqs, 0);
    chk("drop_highs", highs, exp_highs(32, 16));
    cycle(1'b0, 0);
    chk("drop_idle_req", int'(bus.Div_Req), 0);
    chk("drop_idle_out", int'(bus.Div_Out), 0);
    chk("drop_idle_ratio", int'(bus.Cur_Ratio), 32);
    cycle(1'b1, 0);
    chk("reen_idle_req", int'(bus.Div_Req), 0);
    cycle(1'b1, 0);
    chk("reen_load_req", int'(bus.Div_Req), 1);

    // Asynchronous reset between edges while cnt == 10.
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      cycle(1'b1, 0);
      if (m_phase == 2 && (m_n - 1 - m_pos) == 10) begin
        found = 1'b1;
        break;
      end
    end
    chk("arst_reach_cnt10", int'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", int'(bus.Div_Req), 0);
    chk("arst_out", int'(bus.Div_Out), 0);
    chk("arst_ratio", int'(bus.Cur_Ratio), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    lo_last = -1;
    hi_last = -1;
    m_advance(1'b1, 0);
    cycle(1'b1, 0);
    chk("arst_load_req", int'(bus.Div_Req), 1);
    per = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, 0);
      per++;
      if (bus.Div_Req) break;
    end
    chk("arst_period", per, 32);

    // Randomised offsets and enable activity against the model.
    e = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (e) begin
        if ($urandom_range(0, 63) == 0) e = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) e = 1'b1;
      end
      cycle(e, int'($urandom_range(0, 31)) - 16);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
